// File: rtl/square_wave_detector.sv
// Measures the rising-edge period of an asynchronous square wave and locks onto
// the generator's high or low tone after a run of matching periods.
module square_wave_detector #(
    parameter logic [31:0] HighFrequency = 32'd49999,
    parameter logic [31:0] LowFrequency  = 32'd99999,
    parameter logic [31:0] Tolerance     = 32'd500,
    parameter logic [31:0] LockCount     = 32'd2,
    parameter logic [31:0] Timeout       = 32'd200000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in,
    output logic [31:0] period,
    output logic        period_valid,
    output logic        tone_present,
    output logic        frequency_select,
    output logic        timeout
);

    localparam logic [0:0] StIdle    = 1'b0;
    localparam logic [0:0] StMeasure = 1'b1;

    localparam logic [1:0] ClsHigh = 2'd0;
    localparam logic [1:0] ClsLow  = 2'd1;
    localparam logic [1:0] ClsNone = 2'd2;

    localparam logic [31:0] HighPeriod = HighFrequency + 32'd1;
    localparam logic [31:0] LowPeriod  = LowFrequency + 32'd1;

    logic        s1_q, s2_q, s3_q;
    logic        rise;

    logic [0:0]  state_q, state_d;
    logic [31:0] cnt_q, cnt_d;
    logic [31:0] match_cnt_q, match_cnt_d;
    logic        last_class_q, last_class_d;
    logic [31:0] period_q, period_d;
    logic        period_valid_q, period_valid_d;
    logic        tone_q, tone_d;
    logic        fsel_q, fsel_d;
    logic        timeout_q, timeout_d;

    logic [1:0]  cls;
    logic [31:0] match_new;
    logic        last_class_new;
    logic        lock_new;

    // Three flops: two for metastability, the third gives the edge reference.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_q <= 1'b0;
            s2_q <= 1'b0;
            s3_q <= 1'b0;
        end else begin
            s1_q <= in;
            s2_q <= s1_q;
            s3_q <= s2_q;
        end
    end

    assign rise = s2_q & ~s3_q;

    function automatic logic [31:0] abs_diff(input logic [31:0] a, input logic [31:0] b);
        return (a >= b) ? (a - b) : (b - a);
    endfunction

    // The period being captured on a rise is the running count itself.
    always_comb begin
        cls = ClsNone;
        if (abs_diff(cnt_q, HighPeriod) <= Tolerance) begin
            cls = ClsHigh;
        end else if (abs_diff(cnt_q, LowPeriod) <= Tolerance) begin
            cls = ClsLow;
        end
    end

    always_comb begin
        match_new      = 32'd0;
        last_class_new = last_class_q;
        if (cls != ClsNone) begin
            if (cls[0] == last_class_q) begin
                match_new = (match_cnt_q >= LockCount) ? LockCount : match_cnt_q + 32'd1;
            end else begin
                last_class_new = cls[0];
                match_new      = 32'd1;
            end
        end
        lock_new = (cls != ClsNone) && (match_new >= LockCount);
    end

    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        match_cnt_d    = match_cnt_q;
        last_class_d   = last_class_q;
        period_d       = period_q;
        period_valid_d = 1'b0;
        tone_d         = tone_q;
        fsel_d         = fsel_q;
        timeout_d      = 1'b0;

        case (state_q)
            StIdle: begin
                if (rise) begin
                    state_d = StMeasure;
                    cnt_d   = 32'd1;
                end
            end
            StMeasure: begin
                // A rise is evaluated before the timeout so the two never coincide.
                if (rise) begin
                    cnt_d          = 32'd1;
                    period_d       = cnt_q;
                    period_valid_d = 1'b1;
                    match_cnt_d    = match_new;
                    last_class_d   = last_class_new;
                    tone_d         = lock_new;
                    if (lock_new) begin
                        fsel_d = (cls == ClsLow);
                    end
                end else if (cnt_q == Timeout) begin
                    state_d     = StIdle;
                    timeout_d   = 1'b1;
                    tone_d      = 1'b0;
                    match_cnt_d = 32'd0;
                end else begin
                    cnt_d = cnt_q + 32'd1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= StIdle;
            cnt_q          <= 32'd0;
            match_cnt_q    <= 32'd0;
            last_class_q   <= ClsHigh[0];
            period_q       <= 32'd0;
            period_valid_q <= 1'b0;
            tone_q         <= 1'b0;
            fsel_q         <= 1'b0;
            timeout_q      <= 1'b0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            match_cnt_q    <= match_cnt_d;
            last_class_q   <= last_class_d;
            period_q       <= period_d;
            period_valid_q <= period_valid_d;
            tone_q         <= tone_d;
            fsel_q         <= fsel_d;
            timeout_q      <= timeout_d;
        end
    end

    assign period           = period_q;
    assign period_valid     = period_valid_q;
    assign tone_present     = tone_q;
    assign frequency_select = fsel_q;
    assign timeout          = timeout_q;

endmodule

// File: tb/tb_square_wave_detector.sv
// Drives scaled-down tones, tolerance edges, timeouts and random periods; compares the
// recorded output events against an event-level model of edge timing and tone locking.
module tb_square_wave_detector;

    localparam int HiP  = 50;
    localparam int LoP  = 100;
    localparam int Tol  = 5;
    localparam int Lock = 2;
    localparam int To   = 200;
    localparam int Lat  = 3;  // drive edge of a pin rise to the edge that registers its report

    localparam int ClsH = 0;
    localparam int ClsL = 1;
    localparam int ClsN = 2;

    typedef struct {
        int unsigned cyc;
        logic [31:0] period;
        logic        tone;
        logic        fsel;
    } ev_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_r = 1'b0;
    logic [31:0] period;
    logic        period_valid;
    logic        tone_present;
    logic        frequency_select;
    logic        timeout;

    int unsigned cyc = 0;
    int          n_tests = 0;
    int          n_fail = 0;

    ev_t exp_pv[$];
    ev_t obs_pv[$];
    ev_t exp_to[$];
    ev_t obs_to[$];
    ev_t mon_ev;

    bit          m_armed = 1'b0;
    int unsigned m_last = 0;
    int          m_hist[$];
    bit          m_tone = 1'b0;
    bit          m_fsel = 1'b0;

    square_wave_detector #(
        .HighFrequency(32'(HiP - 1)),
        .LowFrequency (32'(LoP - 1)),
        .Tolerance    (32'(Tol)),
        .LockCount    (32'(Lock)),
        .Timeout      (32'(To))
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .in              (in_r),
        .period          (period),
        .period_valid    (period_valid),
        .tone_present    (tone_present),
        .frequency_select(frequency_select),
        .timeout         (timeout)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        forever begin
            @(negedge clk);
            mon_ev.cyc    = cyc;
            mon_ev.period = period;
            mon_ev.tone   = tone_present;
            mon_ev.fsel   = frequency_select;
            if (period_valid === 1'b1) obs_pv.push_back(mon_ev);
            if (timeout === 1'b1) obs_to.push_back(mon_ev);
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    function automatic int classify(input int p);
        int dh;
        int dl;
        dh = (p > HiP) ? p - HiP : HiP - p;
        dl = (p > LoP) ? p - LoP : LoP - p;
        if (dh <= Tol) return ClsH;
        if (dl <= Tol) return ClsL;
        return ClsN;
    endfunction

    // Length of the trailing run of identical classes since the last break.
    function automatic int streak();
        int s;
        s = 0;
        for (int i = m_hist.size() - 1; i >= 0; i--) begin
            if (m_hist[i] == m_hist[m_hist.size() - 1]) s++;
            else break;
        end
        return s;
    endfunction

    task automatic model_timeout(input int unsigned t);
        ev_t ev;
        ev.cyc    = t;
        ev.period = 32'd0;
        ev.tone   = 1'b0;
        ev.fsel   = m_fsel;
        exp_to.push_back(ev);
        m_armed = 1'b0;
        m_tone  = 1'b0;
        m_hist.delete();
    endtask

    task automatic model_flush(input int unsigned now);
        if (m_armed && (m_last + Lat + To <= now)) model_timeout(m_last + Lat + To);
    endtask

    task automatic model_rise(input int unsigned e);
        ev_t ev;
        int  p;
        int  c;
        if (m_armed && (e - m_last > To)) model_timeout(m_last + Lat + To);
        if (m_armed) begin
            p = int'(e - m_last);
            c = classify(p);
            if (c == ClsN) m_hist.delete();
            else m_hist.push_back(c);
            m_tone = (c != ClsN) && (streak() >= Lock);
            if (m_tone) m_fsel = (c == ClsL);
            ev.cyc    = e + Lat;
            ev.period = 32'(p);
            ev.tone   = m_tone;
            ev.fsel   = m_fsel;
            exp_pv.push_back(ev);
        end
        m_armed = 1'b1;
        m_last  = e;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse(input int unsigned p);
        int unsigned h;
        h = p / 2;
        model_rise(cyc);
        in_r = 1'b1;
        repeat (h) tick();
        in_r = 1'b0;
        repeat (p - h) tick();
    endtask

    task automatic apply_reset(input int unsigned n, input bit wiggle);
        model_flush(cyc);
        rst = 1'b1;
        for (int i = 0; i < int'(n); i++) begin
            in_r = wiggle ? ~in_r : 1'b0;
            tick();
        end
        in_r = 1'b0;
        tick();
        check_eq("rst.period", period, 32'd0);
        check_eq("rst.period_valid", 32'(period_valid), 32'd0);
        check_eq("rst.tone_present", 32'(tone_present), 32'd0);
        check_eq("rst.frequency_select", 32'(frequency_select), 32'd0);
        check_eq("rst.timeout", 32'(timeout), 32'd0);
        rst = 1'b0;
        m_armed = 1'b0;
        m_tone  = 1'b0;
        m_fsel  = 1'b0;
        m_hist.delete();
        repeat (4) tick();
    endtask

    task automatic compare_events();
        int n;
        check_eq("pv.count", 32'(obs_pv.size()), 32'(exp_pv.size()));
        n = (obs_pv.size() < exp_pv.size()) ? obs_pv.size() : exp_pv.size();
        for (int i = 0; i < n; i++) begin
            check_eq($sformatf("pv[%0d].cycle", i), obs_pv[i].cyc, exp_pv[i].cyc);
            check_eq($sformatf("pv[%0d].period", i), obs_pv[i].period, exp_pv[i].period);
            check_eq($sformatf("pv[%0d].tone", i), 32'(obs_pv[i].tone), 32'(exp_pv[i].tone));
            check_eq($sformatf("pv[%0d].fsel", i), 32'(obs_pv[i].fsel), 32'(exp_pv[i].fsel));
        end
        check_eq("to.count", 32'(obs_to.size()), 32'(exp_to.size()));
        n = (obs_to.size() < exp_to.size()) ? obs_to.size() : exp_to.size();
        for (int i = 0; i < n; i++) begin
            check_eq($sformatf("to[%0d].cycle", i), obs_to[i].cyc, exp_to[i].cyc);
            check_eq($sformatf("to[%0d].tone", i), 32'(obs_to[i].tone), 32'(exp_to[i].tone));
            check_eq($sformatf("to[%0d].fsel", i), 32'(obs_to[i].fsel), 32'(exp_to[i].fsel));
        end
    endtask

    initial begin
        int unsigned r;
        int unsigned p;
        int unsigned reps;

        apply_reset(3, 1'b1);

        repeat (6) pulse(HiP);
        repeat (6) pulse(LoP);

        // Tolerance edges around both windows, then a single off-tone period while locked.
        repeat (3) pulse(HiP + Tol);
        repeat (3) pulse(HiP + Tol + 1);
        repeat (3) pulse(HiP - Tol);
        repeat (3) pulse(HiP - Tol - 1);
        repeat (3) pulse(HiP);
        pulse(75);
        repeat (3) pulse(HiP);
        repeat (3) pulse(LoP + Tol);
        repeat (2) pulse(LoP + Tol + 1);
        pulse(LoP - Tol);
        pulse(LoP - Tol - 1);

        // A period equal to Timeout is still measured; one longer times out first.
        pulse(To);
        pulse(To + 1);
        repeat (3) pulse(HiP);

        // Locked high tone, then the pin stops.
        repeat (4) pulse(HiP);
        repeat (250) tick();
        repeat (3) pulse(HiP);

        // Switch tones mid-stream.
        repeat (4) pulse(HiP);
        repeat (4) pulse(LoP);

        // Reset in the middle of a measurement.
        repeat (3) pulse(HiP);
        model_rise(cyc);
        in_r = 1'b1;
        repeat (25) tick();
        in_r = 1'b0;
        repeat (10) tick();
        apply_reset(2, 1'b0);
        repeat (3) pulse(HiP);

        for (int k = 0; k < 60; k++) begin
            r = $urandom_range(0, 19);
            if (r < 6) p = $urandom_range(HiP - 8, HiP + 8);
            else if (r < 12) p = $urandom_range(LoP - 8, LoP + 8);
            else if (r < 17) p = $urandom_range(4, 150);
            else p = $urandom_range(To - 10, To + 30);
            reps = $urandom_range(1, 3);
            repeat (reps) pulse(p);
            if ($urandom_range(0, 19) == 0) apply_reset(2, 1'b0);
        end

        repeat (To + 20) tick();
        model_flush(cyc);
        compare_events();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/square_wave_detector.md
# square_wave_detector

Receive-side counterpart of the on-board square-wave tone generator. Measures the period of an asynchronous square-wave input between consecutive rising edges and reports each measurement. It classifies each period as the generator's high-frequency tone, its low-frequency tone, or neither, and declares a tone present after a run of consecutive matching periods. It sits on a loopback or test pin and lets the design confirm which tone, if any, is being driven.

## Interface
Parameters:
- HighFrequency, 32'd49999: generator high-tone reload value; expected period = HighFrequency+1 clocks.
- LowFrequency, 32'd99999: generator low-tone reload value; expected period = LowFrequency+1 clocks.
- Tolerance, 32'd500: maximum accepted |P - expected| in clocks, inclusive.
- LockCount, 32'd2: consecutive same-class periods required before tone_present is asserted; must be ≥1.
- Timeout, 32'd200000: clocks without a rising edge before the lock is dropped; must exceed LowFrequency+1+Tolerance.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  reset; **one clock, reset is synchronous and active-high**.
- in  in  1  asynchronous square-wave input.
- period  out  32  last measured period in clocks.
- period_valid  out  1  one-cycle pulse; period updated this cycle.
- tone_present  out  1  a valid tone is locked.
- frequency_select  out  1  locked tone: 0 = high tone, 1 = low tone. Same encoding as the generator's select input.
- timeout  out  1  one-cycle pulse when the Timeout expires.

## Operation
- Synchronizer: in → s1 → s2 → s3, all flops. rise = s2 & ~s3. The constant latency cancels in period arithmetic.
- States:
  - IDLE: no reference edge; counter cnt is held.
  - MEASURE: cnt counts clocks since the last rise.
- IDLE + rise → MEASURE, cnt ← 1. No period_valid is produced.
- MEASURE, no rise: cnt ← cnt+1.
- MEASURE, rise:
  - P = cnt (value before update). Then cnt ← 1.
  - period ← P, period_valid ← 1. Stay in MEASURE.
- MEASURE, no rise, cnt == Timeout:
  - → IDLE.
  - timeout ← 1, tone_present ← 0, match_cnt ← 0.
  - period and frequency_select hold their values.
- Classification on each captured P:
  - Class H if |P-(HighFrequency+1)| ≤ Tolerance.
  - Class L if |P-(LowFrequency+1)| ≤ Tolerance.
  - Otherwise class N.
  - Compute the absolute difference as a 32-bit unsigned compare-then-subtract; do not use signed wrap.
  - The H and L windows must not overlap; this is a parameter constraint.
- Lock counter match_cnt (32-bit) and last_class:
  - N: match_cnt ← 0, tone_present ← 0.
  - Class == last_class: match_cnt ← min(match_cnt+1, LockCount).
  - Class ≠ last_class: last_class ← class, match_cnt ← 1.
  - tone_present ← (new match_cnt ≥ LockCount).
  - When tone_present is set, frequency_select ← (class == L). Otherwise frequency_select holds.
- Reset:
  - s1..s3 ← 0; state ← IDLE; cnt ← 0; match_cnt ← 0; last_class ← H.
  - All outputs ← 0.
  - Reset during a measurement discards the measurement. The first rise after reset only arms MEASURE.

## Timing
- A pin rising edge at cycle t produces rise at t+2 or t+3, depending on the metastability window.
- period_valid, period, tone_present and frequency_select update together, on the clock after rise is seen.
- Rises at rise-cycles r0 and r1 give P = r1-r0 exactly.
- The timeout pulse fires Timeout cycles after the last rise-cycle. At most one timeout pulse per IDLE entry.
- A rise and timeout cannot coincide: the rise takes priority because it is evaluated first.
- All outputs are registered; no combinational path from in.

## Test plan
- Reset: assert rst for 3 cycles with in toggling. Required: all outputs 0, and no period_valid before the second post-reset rise.
- High tone, 25000 clocks high / 25000 low: period_valid pulses with period=50000 on each rise after the first. tone_present rises with the 2nd measured period; frequency_select=0.
- Low tone, 50000/50000: period=100000 each measurement. tone_present after 2 periods; frequency_select=1.
- Tolerance edges:
  - Periods of 50500 → class H.
  - Periods of 50501 → class N, tone_present 0.
  - A single 75000 period while locked → tone_present drops the same cycle as period_valid.
- Locked high tone, then in held at 0: a timeout pulse arrives exactly 200000 cycles after the last rise, tone_present → 0. The next rise produces no period_valid; the one after reports its true period.
- Switch from 50000 to 100000 mid-stream: tone_present drops on the first 100000 period and reasserts on the second with frequency_select=1. Also assert rst mid-period: outputs clear and measurement restarts.
